// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator: pixel divider, h/v counters, registered sync/visible decode
module vga_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic [9:0] hPos,
    output logic [8:0] vPos,
    output logic       pixEn,
    output logic       frameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [8:0] V_POS_MAX    = 9'(V_VISIBLE - 1);

    logic [DIV_W-1:0] div;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             tick;

    assign tick = (div == DIV_LAST);

    // Line wrap and frame wrap resolve together, so vCount moves at most once per tick.
    always_comb begin
        h_next = h_count + 10'd1;
        v_next = v_count;
        if (h_count == H_LAST) begin
            h_next = '0;
            v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
        end
    end

    // Outputs decode the next-state counters so they change on the same edge as the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            h_count    <= H_LAST;
            v_count    <= V_LAST;
            hPos       <= H_LAST;
            vPos       <= V_POS_MAX;
            bright     <= 1'b0;
            hSync      <= 1'b1;
            vSync      <= 1'b1;
            pixEn      <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            pixEn      <= tick;
            frameStart <= tick && (h_next == '0) && (v_next == '0);
            if (tick) begin
                div     <= '0;
                h_count <= h_next;
                v_count <= v_next;
                hPos    <= h_next;
                vPos    <= (v_next < V_VIS) ? v_next[8:0] : V_POS_MAX;
                bright  <= (h_next < H_VIS) && (v_next < V_VIS);
                hSync   <= !((h_next >= H_SYNC_START) && (h_next < H_SYNC_END));
                vSync   <= !((v_next >= V_SYNC_START) && (v_next < V_SYNC_END));
            end else begin
                div <= div + DIV_ONE;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - self-checking bench for vga_timing: vector table, elapsed-time reference model, random resets
module tb_vga_timing;

    localparam int NCYC = 20000;
    localparam int NTAB = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic hs_a, vs_a, br_a, pe_a, fs_a;
    logic hs_b, vs_b, br_b, pe_b, fs_b;
    logic hs_c, vs_c, br_c, pe_c, fs_c;
    logic [9:0] hp_a, hp_b, hp_c;
    logic [8:0] vp_a, vp_b, vp_c;

    vga_timing dut_a (
        .clk(clk), .rst(rst_a), .hSync(hs_a), .vSync(vs_a), .bright(br_a),
        .hPos(hp_a), .vPos(vp_a), .pixEn(pe_a), .frameStart(fs_a)
    );

    vga_timing #(
        .CLK_DIV(2), .H_VISIBLE(20), .H_FP(2), .H_SYNC(4), .H_BP(4),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_b (
        .clk(clk), .rst(rst_b), .hSync(hs_b), .vSync(vs_b), .bright(br_b),
        .hPos(hp_b), .vPos(vp_b), .pixEn(pe_b), .frameStart(fs_b)
    );

    vga_timing #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_c (
        .clk(clk), .rst(rst_c), .hSync(hs_c), .vSync(vs_c), .bright(br_c),
        .hPos(hp_c), .vPos(vp_c), .pixEn(pe_c), .frameStart(fs_c)
    );

    // Packed as {hSync, vSync, bright, pixEn, frameStart, hPos, vPos}
    logic [23:0] act_a, act_b, act_c;
    assign act_a = {hs_a, vs_a, br_a, pe_a, fs_a, hp_a, vp_a};
    assign act_b = {hs_b, vs_b, br_b, pe_b, fs_b, hp_b, vp_b};
    assign act_c = {hs_c, vs_c, br_c, pe_c, fs_c, hp_c, vp_c};

    typedef struct {
        int         k;
        logic [9:0] h;
        logic [8:0] v;
        logic       b;
        logic       hs;
        logic       vs;
        logic       pe;
        logic       fs;
    } vec_t;

    vec_t tab [NTAB];

    int checks;
    int failures;

    function automatic vec_t mk(int k, int h, int v, logic b, logic hs, logic vs, logic pe, logic fs);
        vec_t r;
        r.k  = k;
        r.h  = 10'(h);
        r.v  = 9'(v);
        r.b  = b;
        r.hs = hs;
        r.vs = vs;
        r.pe = pe;
        r.fs = fs;
        return r;
    endfunction

    // Expected outputs after k clock edges since reset release, from raster arithmetic alone.
    function automatic logic [23:0] expect_vec(int k, int cd, int hv, int hfp, int hsw, int hbp,
                                               int vv, int vfp, int vsw, int vbp);
        int ht, vt, h, v, m, vpos;
        logic pe, fs, hs, vs, b;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        if (k < cd) begin
            h  = ht - 1;
            v  = vt - 1;
            pe = 1'b0;
        end else begin
            m  = k / cd - 1;
            h  = m % ht;
            v  = (m / ht) % vt;
            pe = ((k % cd) == 0);
        end
        fs   = pe && (h == 0) && (v == 0);
        hs   = !((h >= hv + hfp) && (h < hv + hfp + hsw));
        vs   = !((v >= vv + vfp) && (v < vv + vfp + vsw));
        b    = (h < hv) && (v < vv);
        vpos = (v < vv) ? v : vv - 1;
        return {hs, vs, b, pe, fs, 10'(h), 9'(vpos)};
    endfunction

    task automatic check_vec(string name, logic [23:0] act, logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {hs,vs,br,pe,fs,h,v}=%b_%b_%b_%b_%b_%0d_%0d expected %b_%b_%b_%b_%b_%0d_%0d",
                     name, act[23], act[22], act[21], act[20], act[19], act[18:9], act[8:0],
                     exp[23], exp[22], exp[21], exp[20], exp[19], exp[18:9], exp[8:0]);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int   k_a, k_b, k_c;
        int   b_left, bcnt, hcnt;
        int   b_fs_cyc, b_pe_cyc, c_fs_cyc;
        logic a_first, a_mid, a_post, b_tick_done;
        logic b_fs_valid, b_pe_valid, c_fs_valid;

        checks   = 0;
        failures = 0;

        tab[0]  = mk(0,    799, 479, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tab[1]  = mk(1,    799, 479, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tab[2]  = mk(2,    0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tab[3]  = mk(3,    0,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tab[4]  = mk(1280, 639, 0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tab[5]  = mk(1282, 640, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tab[6]  = mk(1314, 656, 0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tab[7]  = mk(1504, 751, 0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tab[8]  = mk(1506, 752, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tab[9]  = mk(1600, 799, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tab[10] = mk(1602, 0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tab[11] = mk(1603, 0,   1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        k_a = 0; k_b = 0; k_c = 0;
        b_left = 0; bcnt = 0; hcnt = 0;
        b_fs_cyc = 0; b_pe_cyc = 0; c_fs_cyc = 0;
        a_first = 1'b1; a_mid = 1'b0; a_post = 1'b0; b_tick_done = 1'b0;
        b_fs_valid = 1'b0; b_pe_valid = 1'b0; c_fs_valid = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            rst_a = (cyc < 3);
            // One-clk reset in the middle of line 1 at hPos=300
            if (a_first && k_a == 2203) begin
                rst_a   = 1'b1;
                a_first = 1'b0;
                a_mid   = 1'b1;
            end
            rst_c = (cyc < 4);
            if (b_left > 0) begin
                rst_b = 1'b1;
                b_left--;
            end else if (cyc < 2) begin
                rst_b = 1'b1;
            end else if (!b_tick_done && cyc >= 6000 && (k_b % 2) == 1) begin
                rst_b       = 1'b1;
                b_tick_done = 1'b1;
            end else if ($urandom_range(0, 2499) == 0) begin
                rst_b  = 1'b1;
                b_left = int'($urandom_range(0, 2));
            end else begin
                rst_b = 1'b0;
            end

            @(posedge clk);
            k_a = rst_a ? 0 : k_a + 1;
            k_b = rst_b ? 0 : k_b + 1;
            k_c = rst_c ? 0 : k_c + 1;
            if (rst_b) begin
                b_fs_valid = 1'b0;
                b_pe_valid = 1'b0;
            end
            if (rst_c) c_fs_valid = 1'b0;

            @(negedge clk);
            check_vec("model_a", act_a, expect_vec(k_a, 2, 640, 16, 96, 48, 480, 10, 2, 33));
            check_vec("model_b", act_b, expect_vec(k_b, 2, 20, 2, 4, 4, 12, 2, 2, 3));
            check_vec("model_c", act_c, expect_vec(k_c, 1, 8, 2, 3, 3, 4, 1, 1, 1));

            if (a_first) begin
                for (int i = 0; i < NTAB; i++) begin
                    if (tab[i].k == k_a)
                        check_vec($sformatf("table_a[%0d]", i), act_a,
                                  {tab[i].hs, tab[i].vs, tab[i].b, tab[i].pe, tab[i].fs, tab[i].h, tab[i].v});
                end
                if (k_a >= 2 && k_a <= 1601) begin
                    if (br_a) bcnt++;
                    if (!hs_a) hcnt++;
                end
                if (k_a == 1601) begin
                    check_int("line_bright_clks", bcnt, 1280);
                    check_int("line_hsync_low_clks", hcnt, 192);
                end
            end

            if (a_mid) begin
                check_vec("mid_reset_vals", act_a, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd799, 9'd479});
                a_mid  = 1'b0;
                a_post = 1'b1;
            end else if (a_post && k_a == 2) begin
                check_vec("mid_restart", act_a, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 9'd0});
                a_post = 1'b0;
            end

            if (fs_b) begin
                if (b_fs_valid) check_int("b_frame_period", cyc - b_fs_cyc, 1140);
                b_fs_cyc   = cyc;
                b_fs_valid = 1'b1;
            end
            if (pe_b) begin
                if (b_pe_valid) check_int("b_pixen_spacing", cyc - b_pe_cyc, 2);
                b_pe_cyc   = cyc;
                b_pe_valid = 1'b1;
            end

            if (k_c >= 1) check_int("c_pixen_const", int'(pe_c), 1);
            if (fs_c) begin
                if (c_fs_valid) check_int("c_frame_period", cyc - c_fs_cyc, 112);
                c_fs_cyc   = cyc;
                c_fs_valid = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the paint display pipeline. It divides the system clock down to the pixel rate and runs horizontal and vertical counters over a full 640x480 frame including blanking. From those counters it produces the sync pulses, the `bright` visible-area flag and the `hPos`/`vPos` coordinates. It sits directly upstream of the bit generator, which consumes `bright`, `hPos` and `vPos` each pixel. `hSync`/`vSync` go to the VGA connector.

## Interface

Parameters:

- `CLK_DIV`, 2: system clocks per pixel (50 MHz -> 25 MHz); must be >= 1
- `H_VISIBLE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_VISIBLE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines

Ports:

- `clk`, in, 1: system clock; one clock domain, all logic on rising edge
- `rst`, in, 1: reset, synchronous, active-high
- `hSync`, out, 1: horizontal sync, active low
- `vSync`, out, 1: vertical sync, active low
- `bright`, out, 1: high only when the pixel is in the visible area
- `hPos`, out, 10: current pixel column (0..H_TOTAL-1)
- `vPos`, out, 9: current visible line (0..V_VISIBLE-1), saturating
- `pixEn`, out, 1: one-clk strobe at the start of each pixel period
- `frameStart`, out, 1: one-clk pulse when the raster wraps to (0,0)

## Operation

- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Divider counter `div`: counts 0..CLK_DIV-1 and wraps. `tick` = (div == CLK_DIV-1). With CLK_DIV=1, tick is high every clk.
- On tick, advance `hCount`:
  - If hCount == H_TOTAL-1, hCount <- 0 and vCount advances.
  - vCount wraps from V_TOTAL-1 to 0.
  - Otherwise hCount increments.
  - Both counters are 10 bits.
- Decode of the counters:
  - `hSync` = 0 iff H_VISIBLE+H_FP <= hCount < H_VISIBLE+H_FP+H_SYNC (656..751).
  - `vSync` = 0 iff V_VISIBLE+V_FP <= vCount < V_VISIBLE+V_FP+V_SYNC (490..491).
  - `bright` = (hCount < H_VISIBLE) && (vCount < V_VISIBLE).
  - `hPos` = hCount.
  - `vPos` = vCount[8:0] when vCount < V_VISIBLE, else V_VISIBLE-1 (479). No 9-bit wrap is ever presented downstream.
- `pixEn`: registered; high for the single clk in which the new counter values first appear on the outputs.
- `frameStart`: high for the single clk in which the counters first show (0,0).
- No other states. The block free-runs from reset release; it has no enable and no stall.

## Timing

- All outputs are registered, and all update on the same clk edge as the counters. hSync/vSync/bright/hPos/vPos never disagree with one another for any cycle. Latency from counter to output is 0, because the decode uses next-state values.
- On reset, rst high at an edge forces:
  - div=0, hCount=H_TOTAL-1, vCount=V_TOTAL-1
  - hPos=799, vPos=479, bright=0, hSync=1, vSync=1, pixEn=0, frameStart=0
- Reset mid-frame: the same values apply on the next edge regardless of state; there is no partial-line completion.
- After release: the CLK_DIV-th edge after rst is sampled low produces hPos=0, vPos=0, bright=1, pixEn=1, frameStart=1.
- Each output value is held for exactly CLK_DIV clks.
- Line period is H_TOTAL×CLK_DIV clks (1600). Frame period is H_TOTAL×V_TOTAL×CLK_DIV clks (840,000).
- hSync low for H_SYNC×CLK_DIV clks (192) per line.
- vSync low for exactly V_SYNC full lines. Its edges coincide with hPos=0.
- The line wrap and the frame wrap happen on the same tick when hCount=H_TOTAL-1 and vCount=V_TOTAL-1. frameStart fires once; vCount does not double-increment.
- rst asserted on the same edge as a tick: reset wins, and no pixEn is produced.

## Test plan

- Reset values: hold rst for 3 clks, then check hPos=799, vPos=479, bright=0, hSync=1, vSync=1, pixEn=0, frameStart=0. Release rst; exactly 2 clks later check hPos=0, vPos=0, bright=1, pixEn=1, frameStart=1.
- Horizontal timing: across one line, check:
  - bright high for 1280 clks, then low for 320
  - hSync falls on the edge where hPos becomes 656 and rises where hPos becomes 752 (192 clks low)
  - hPos goes 799 -> 0, with vPos incrementing on that same edge
- Vertical timing: across one frame, check:
  - vSync low only while vCount=490..491 (3200 clks), edges aligned to hPos=0
  - vPos holds 479 for all of lines 480..524
  - bright never high in those lines
- Frame period: frameStart pulses are exactly 840,000 clks apart. pixEn pulses number 420,000 per frame and are exactly 2 clks apart.
- Mid-frame reset: assert rst for 1 clk at hPos=300, vPos=200. Check the reset values on the next edge, then a clean restart to (0,0) 2 clks after release.
- Parameter sweep: CLK_DIV=1 with H_VISIBLE=8, H_FP=2, H_SYNC=3, H_BP=3, V_VISIBLE=4, V_FP=1, V_SYNC=1, V_BP=1. pixEn stays constantly high after release, and the frame period is 16×7=112 clks.
